// File: rtl/router_arbiter.sv
// Four-port round-robin router arbiter: grants one dataport, waits for the router's
// acknowledge, then sequences a BURST_LEN store burst followed by a BURST_LEN forward burst.
module router_arbiter #(
  parameter int BURST_LEN   = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] request,
  input  logic       acknowledge,
  output logic [3:0] grant,
  output logic       st_router,
  output logic       fw_router,
  output logic [3:0] inAddr,
  output logic [3:0] outAddr,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    STORE    = 2'd2,
    FORWARD  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ADDR = 4'(BURST_LEN - 1);
  localparam logic [3:0] LAST_WAIT = 4'(ACK_TIMEOUT - 1);

  state_t     state_r;
  logic [1:0] rr_ptr_r;
  logic [3:0] wait_cnt_r;
  logic [1:0] pick_s;

  // First requesting port at or after start, wrapping port 4 back to port 1
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Round-robin candidate among the current requests
  always_comb begin
    pick_s = rr_pick(request, rr_ptr_r);
  end

  // Transaction sequencer; every output is a register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= 2'd0;
      wait_cnt_r  <= 4'd0;
      grant       <= 4'd0;
      st_router   <= 1'b0;
      fw_router   <= 1'b0;
      inAddr      <= 4'd0;
      outAddr     <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|request) begin
            // pointer moves past the chosen port now, so an abandoned grant also advances it
            grant      <= 4'b0001 << pick_s;
            rr_ptr_r   <= pick_s + 2'd1;
            wait_cnt_r <= 4'd0;
            busy       <= 1'b1;
            state_r    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (acknowledge) begin
            st_router <= 1'b1;
            inAddr    <= 4'd0;
            state_r   <= STORE;
          end else if (wait_cnt_r == LAST_WAIT) begin
            grant       <= 4'd0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        STORE: begin
          if (inAddr == LAST_ADDR) begin
            st_router <= 1'b0;
            fw_router <= 1'b1;
            outAddr   <= 4'd0;
            grant     <= 4'd0;
            state_r   <= FORWARD;
          end else begin
            inAddr <= inAddr + 4'd1;
          end
        end
        FORWARD: begin
          if (outAddr == LAST_ADDR) begin
            fw_router <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_r   <= IDLE;
          end else begin
            outAddr <= outAddr + 4'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          grant     <= 4'd0;
          st_router <= 1'b0;
          fw_router <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
